// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module  : regfile_wb_arbiter
// Brief   : Round-robin arbiter sharing one register-file write port among
//           NUM_REQ writeback sources; winner's write is registered (latency 1).
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        hold,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        wd_en,
  output logic [ADDR_W-1:0]           wd_sel,
  output logic [DATA_W-1:0]           data,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

  localparam int                c_ID_W    = $clog2(NUM_REQ);
  localparam logic [c_ID_W:0]   c_NUM     = (c_ID_W+1)'(NUM_REQ);
  localparam logic [c_ID_W-1:0] c_LAST_ID = c_ID_W'(NUM_REQ - 1);

  logic [ADDR_W-1:0] w_addr_arr [NUM_REQ];
  logic [DATA_W-1:0] w_data_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign w_data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  logic [c_ID_W-1:0]  r_rr_ptr;
  logic               r_wd_en;
  logic [ADDR_W-1:0]  r_wd_sel;
  logic [DATA_W-1:0]  r_data;
  logic [c_ID_W-1:0]  r_grant_id;

  logic [NUM_REQ-1:0] w_ready;
  logic [c_ID_W-1:0]  w_gnt_idx;
  logic [c_ID_W-1:0]  w_scan_idx;
  logic [c_ID_W:0]    w_sum;
  logic               w_found;
  logic               w_xfer;
  logic [ADDR_W-1:0]  w_gnt_addr;
  logic [DATA_W-1:0]  w_gnt_data;
  logic [c_ID_W-1:0]  w_ptr_next;

  // Scan rr_ptr, rr_ptr+1, ... (mod NUM_REQ); the first valid requester wins.
  always_comb begin
    w_ready    = '0;
    w_gnt_idx  = '0;
    w_scan_idx = '0;
    w_sum      = '0;
    w_found    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (c_ID_W+1)'(k);
      if (w_sum >= c_NUM) begin
        w_sum = w_sum - c_NUM;
      end
      w_scan_idx = w_sum[c_ID_W-1:0];
      if (!w_found && req_valid[w_scan_idx]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_scan_idx;
      end
    end
    if (w_found && !hold && rst) begin
      w_ready[w_gnt_idx] = 1'b1;
    end
  end

  assign w_xfer     = |w_ready;
  assign w_gnt_addr = w_addr_arr[w_gnt_idx];
  assign w_gnt_data = w_data_arr[w_gnt_idx];
  assign w_ptr_next = (w_gnt_idx == c_LAST_ID) ? '0 : w_gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr   <= '0;
      r_wd_en    <= 1'b0;
      r_wd_sel   <= '0;
      r_data     <= '0;
      r_grant_id <= '0;
    end else begin
      r_wd_en <= 1'b0;
      if (w_xfer) begin
        r_rr_ptr   <= w_ptr_next;
        r_wd_sel   <= w_gnt_addr;
        r_data     <= w_gnt_data;
        r_grant_id <= w_gnt_idx;
        // x0 is hardwired: handshake it but never write it.
        r_wd_en    <= |w_gnt_addr;
      end
    end
  end

  assign req_ready = w_ready;
  assign wd_en     = r_wd_en;
  assign wd_sel    = r_wd_sel;
  assign data      = r_data;
  assign grant_id  = r_grant_id;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module  : tb_regfile_wb_arbiter
// Brief   : Directed self-checking bench for regfile_wb_arbiter (3 requesters).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic                       hold = 1'b0;
  logic [NUM_REQ-1:0]         req_valid = '0;
  logic [NUM_REQ*ADDR_W-1:0]  req_addr = '0;
  logic [NUM_REQ*DATA_W-1:0]  req_data = '0;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       wd_en;
  logic [ADDR_W-1:0]          wd_sel;
  logic [DATA_W-1:0]          data;
  logic [1:0]                 grant_id;

  int n_cmp = 0;
  int n_err = 0;

  regfile_wb_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wd_en     (wd_en),
    .wd_sel    (wd_sel),
    .data      (data),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_port(input string tag, input logic en, input logic [ADDR_W-1:0] sel,
                            input logic [DATA_W-1:0] d, input logic [1:0] gid);
    check({tag, ".wd_en"},    64'(wd_en),    64'(en));
    check({tag, ".wd_sel"},   64'(wd_sel),   64'(sel));
    check({tag, ".data"},     64'(data),     64'(d));
    check({tag, ".grant_id"}, 64'(grant_id), 64'(gid));
  endtask

  int exp_gnt [4] = '{1, 2, 0, 1};
  int t2_addr [3] = '{1, 2, 4};
  int t2_data [3] = '{10, 20, 30};

  initial begin
    // Reset state; a valid request during reset must not see ready.
    req_valid = 3'b001;
    set_req(0, 5'd3, 32'd43);
    #2;
    check("rst.ready", 64'(req_ready), 64'd0);
    check_port("rst", 1'b0, 5'd0, 32'd0, 2'd0);
    #10;
    rst = 1'b1;
    #1;

    // Test 1: single request after reset.
    check("t1.ready", 64'(req_ready), 64'b001);
    tick();
    check_port("t1", 1'b1, 5'd3, 32'd43, 2'd0);
    req_valid = 3'b000;
    tick();
    check_port("t1.idle", 1'b0, 5'd3, 32'd43, 2'd0);

    // Test 2: all valid, rr_ptr=1 -> grants 1,2,0,1 back to back.
    for (int i = 0; i < 3; i++) set_req(i, 5'(t2_addr[i]), 32'(t2_data[i]));
    req_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("t2.ready%0d", k), 64'(req_ready), 64'(1 << exp_gnt[k]));
      tick();
      check_port($sformatf("t2.wr%0d", k), 1'b1, 5'(t2_addr[exp_gnt[k]]),
                 32'(t2_data[exp_gnt[k]]), 2'(exp_gnt[k]));
    end
    req_valid = 3'b000;
    tick();

    // Test 3: write to x0 from req1 (rr_ptr=2): handshaken, no write enable.
    set_req(1, 5'd0, 32'd99);
    req_valid = 3'b010;
    #1;
    check("t3.ready", 64'(req_ready), 64'b010);
    tick();
    check_port("t3", 1'b0, 5'd0, 32'd99, 2'd1);
    // Pointer now 2: with req0 and req1 valid, req0 wins.
    set_req(0, 5'd6, 32'd1);
    set_req(1, 5'd9, 32'd2);
    req_valid = 3'b011;
    #1;
    check("t3.ptr", 64'(req_ready), 64'b001);
    tick();
    req_valid = 3'b000;
    tick();

    // Test 4: same-address collision with rr_ptr=1 -> req2 then req0.
    set_req(0, 5'd5, 32'd7);
    set_req(2, 5'd5, 32'd8);
    req_valid = 3'b101;
    #1;
    check("t4.ready0", 64'(req_ready), 64'b100);
    tick();
    check_port("t4.wr0", 1'b1, 5'd5, 32'd8, 2'd2);
    req_valid = 3'b001;
    #1;
    check("t4.ready1", 64'(req_ready), 64'b001);
    tick();
    check_port("t4.wr1", 1'b1, 5'd5, 32'd7, 2'd0);

    // Test 5: hold for 3 cycles; the write already registered still shows.
    hold = 1'b1;
    set_req(0, 5'd11, 32'd66);
    set_req(1, 5'd7, 32'd55);
    req_valid = 3'b011;
    #1;
    check("t5.inflight", 64'(wd_en), 64'd1);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t5.ready%0d", k), 64'(req_ready), 64'd0);
      tick();
      check($sformatf("t5.wd_en%0d", k), 64'(wd_en), 64'd0);
    end
    hold = 1'b0;
    #1;
    check("t5.release", 64'(req_ready), 64'b010);
    tick();
    check_port("t5.wr", 1'b1, 5'd7, 32'd55, 2'd1);

    // Test 6: async reset while a write is on the port (rr_ptr=2 -> req0).
    set_req(0, 5'd12, 32'd77);
    req_valid = 3'b001;
    tick();
    check_port("t6.pre", 1'b1, 5'd12, 32'd77, 2'd0);
    #2;
    rst = 1'b0;
    #1;
    check_port("t6.async", 1'b0, 5'd0, 32'd0, 2'd0);
    check("t6.ready_rst", 64'(req_ready), 64'd0);
    #3;
    rst = 1'b1;
    req_valid = 3'b011;
    #1;
    check("t6.ptr0", 64'(req_ready), 64'b001);
    tick();
    check_port("t6.post", 1'b1, 5'd12, 32'd77, 2'd0);
    req_valid = 3'b000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
